// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and the MEM stage, one transaction at a time.
// Define ARB_STARVE_GUARD_EN to compile in the fetch starvation counter and forced fetch grant.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [63:0]       dm_wdata,
    input  logic [2:0]        dm_RW_type,
    output logic [63:0]       dm_rdata,
    output logic              dm_valid,
    output logic              stall_dm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [2:0]        mem_RW_type,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arbStateT;

    arbStateT state, nextState;

    logic ownerIf;      // current transaction belongs to fetch
    logic ifHalfHi;     // latched if_addr[2], selects the instruction word
    logic ifFlushed;    // fetch was cancelled after it left IDLE
    logic ifReqEff;
    logic forceIf;
    logic grantIf;
    logic grantDm;

    // A flush in IDLE hides the fetch request for that cycle.
    assign ifReqEff = if_req & ~if_flush;
    assign grantIf  = ifReqEff & (~dm_req | forceIf);
    assign grantDm  = dm_req & ~grantIf;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starveCnt;

    assign forceIf = (starveCnt == 4'(STARVE_MAX));

    // A DM win over a waiting fetch implies starveCnt < STARVE_MAX, so the increment saturates by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt <= '0;
        end else if (state == IDLE) begin
            starveCnt <= (ifReqEff && grantDm) ? starveCnt + 4'd1 : 4'd0;
        end
    end
`else
    logic [3:0] unusedStarveMax;

    assign forceIf         = 1'b0;
    assign unusedStarveMax = 4'(STARVE_MAX);
`endif

    logic [1:0] unusedIfAddrLsb;
    assign unusedIfAddrLsb = if_addr[1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: nextState gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (grantIf || grantDm) nextState = ISSUE;
            ISSUE:   if (mem_gnt) nextState = WAIT;
            WAIT:    if (mem_rvalid) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_RW_type <= '0;
            ownerIf     <= 1'b0;
            ifHalfHi    <= 1'b0;
            ifFlushed   <= 1'b0;
            if_valid    <= 1'b0;
            dm_valid    <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    ifFlushed <= 1'b0;
                    if (grantIf) begin
                        ownerIf     <= 1'b1;
                        ifHalfHi    <= if_addr[2];
                        mem_we      <= 1'b0;
                        mem_addr    <= {if_addr[ADDR_W-1:3], 3'b000};
                        mem_wdata   <= '0;
                        mem_RW_type <= 3'b010;
                    end else if (grantDm) begin
                        ownerIf     <= 1'b0;
                        mem_we      <= dm_we;
                        mem_addr    <= dm_addr;
                        mem_wdata   <= dm_wdata;
                        mem_RW_type <= dm_RW_type;
                    end
                end
                ISSUE, WAIT: begin
                    if (ownerIf && if_flush) ifFlushed <= 1'b1;
                    // The cancelled fetch still drains the memory response, it just never reports.
                    if (state == WAIT && mem_rvalid) begin
                        if (ownerIf) begin
                            if (!(ifFlushed || if_flush)) begin
                                if_valid <= 1'b1;
                                if_rdata <= ifHalfHi ? mem_rdata[63:32] : mem_rdata[31:0];
                            end
                        end else begin
                            dm_valid <= 1'b1;
                            dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req  = (state == ISSUE);
    assign stall_if = if_req & ~if_valid;
    assign stall_dm = dm_req & ~dm_valid;

endmodule
